// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-binary converter:
//   - state_e     : converter FSM states (IDLE, CONV, FIN)
//   - DIGITS_DEF  : default number of BCD digits
//   - BIN_W_DEF   : default binary result width
//   - BCD_MAX     : largest value representable in DIGITS_DEF digits
//   - digit_valid : true when a nibble is a legal BCD digit (0..9)
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int DIGITS_DEF = 6;
  localparam int BIN_W_DEF  = 20;
  localparam int BCD_MAX    = 999999;

  // A nibble is a legal BCD digit only in the range 0..9.
  function automatic logic digit_valid(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// ---------------------------------------------------------------------------
// bcd_mul10_add
// Combinational acc*10 + digit built from shifts and adds:
//   (acc<<3) + (acc<<1) + digit, evaluated on BIN_W+4 bits.
// Ports:
//   acc_i    in  BIN_W  current accumulator
//   digit_i  in  4      next BCD digit (most significant remaining)
//   result_o out BIN_W  truncated result
//   ovf_o    out 1      result did not fit in BIN_W bits
// ---------------------------------------------------------------------------
module bcd_mul10_add
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic [BIN_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [BIN_W-1:0] result_o,
  output logic             ovf_o
);

  logic [BIN_W+3:0] acc_ext_s;
  logic [BIN_W+3:0] sum_s;

  // Multiply by ten as x*8 + x*2, then add the incoming digit.
  always_comb begin
    acc_ext_s = {4'b0000, acc_i};
    sum_s     = (acc_ext_s << 3) + (acc_ext_s << 1) + {{BIN_W{1'b0}}, digit_i};
    result_o  = sum_s[BIN_W-1:0];
    ovf_o     = |sum_s[BIN_W+3:BIN_W];
  end

endmodule

// File: rtl/bcd6_to_bin.sv
// ---------------------------------------------------------------------------
// bcd6_to_bin
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Ports:
//   CLK      in  1         rising-edge clock
//   CLR      in  1         asynchronous active-high reset
//   START    in  1         conversion request, sampled while BUSY=0
//   BCD_IN   in  4*DIGITS  packed BCD, digit 0 in [3:0]
//   BUSY     out 1         conversion in progress
//   DONE     out 1         one-cycle pulse, BIN_OUT/ERR valid
//   BIN_OUT  out BIN_W     converted value (all-ones on invalid input)
//   ERR      out 1         last conversion contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd6_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [BIN_W-1:0]      BIN_OUT,
  output logic                  ERR
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inv_q, inv_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  inv_in_s;
  logic                  capture_s;
  logic                  last_step_s;
  logic [BIN_W-1:0]      mul_res_s;
  logic                  mul_ovf_s;

  bcd_mul10_add #(.BIN_W(BIN_W)) u_mul10_add (
    .acc_i    (acc_q),
    .digit_i  (sr_q[4*DIGITS-1 -: 4]),
    .result_o (mul_res_s),
    .ovf_o    (mul_ovf_s)
  );

  // Flag any illegal nibble in the word presented at BCD_IN.
  always_comb begin
    inv_in_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(BCD_IN[4*i +: 4])) begin
        inv_in_s = 1'b1;
      end else begin
        inv_in_s = inv_in_s;
      end
    end
  end

  // START is honoured only when not busy: in IDLE, or in FIN for back-to-back.
  always_comb begin
    capture_s   = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    last_step_s = (cnt_q == CNT_W'(DIGITS));
  end

  // State register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. CONV spends one extra cycle (counter == DIGITS) to
  // publish the result, which gives the DIGITS+2 back-to-back period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = capture_s ? ST_CONV : ST_IDLE;
      ST_CONV: state_d = last_step_s ? ST_FIN : ST_CONV;
      ST_FIN:  state_d = capture_s ? ST_CONV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    bin_d  = bin_q;
    err_d  = err_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (capture_s) begin
          sr_d   = BCD_IN;
          acc_d  = {BIN_W{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          inv_d  = inv_in_s;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (last_step_s) begin
          bin_d  = inv_q ? {BIN_W{1'b1}} : acc_q;
          err_d  = inv_q;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          acc_d  = mul_res_s;
          sr_d   = {sr_q[4*DIGITS-5:0], 4'h0};
          cnt_d  = cnt_q + CNT_W'(1);
          // Overflow is only reachable with illegal digits; folding it in
          // keeps a corrupted accumulator from ever being reported as valid.
          inv_d  = inv_q | mul_ovf_s;
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sr_q   <= {(4*DIGITS){1'b0}};
      acc_q  <= {BIN_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      inv_q  <= 1'b0;
      bin_q  <= {BIN_W{1'b0}};
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
      bin_q  <= bin_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIN_OUT = bin_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_bcd6_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd6_to_bin
// Directed and randomized bench for bcd6_to_bin with a decimal-arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_bcd6_to_bin;

  logic        CLK;
  logic        CLR;
  logic        START;
  logic [23:0] BCD_IN;
  logic        BUSY;
  logic        DONE;
  logic [19:0] BIN_OUT;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  bcd6_to_bin dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .START   (START),
    .BCD_IN  (BCD_IN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .BIN_OUT (BIN_OUT),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: weighted decimal sum; any nibble above 9 forces all-ones + ERR.
  function automatic void model(input logic [23:0] bcd, output logic [19:0] v, output logic e);
    int sum;
    int pw;
    int d;
    sum = 0;
    pw  = 1;
    e   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) e = 1'b1;
      sum = sum + d * pw;
      pw  = pw * 10;
    end
    v = e ? 20'hFFFFF : sum[19:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One conversion from idle: checks latency, result, error flag, DONE width.
  task automatic run_conv(input logic [23:0] bcd, input string tag);
    logic [19:0] ev;
    logic        ee;
    int          lat;
    model(bcd, ev, ee);
    BCD_IN = bcd;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    BCD_IN = 24'($urandom);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
    lat = 0;
    while (DONE !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd7);
    chk({tag, "_bin"}, {12'd0, BIN_OUT}, {12'd0, ev});
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, ee});
    chk({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
    tick();
    chk({tag, "_done_clear"}, {31'd0, DONE}, 32'd0);
  endtask

  initial begin
    logic [23:0] rb;
    logic [19:0] ev;
    logic        ee;
    int          dcnt;
    int          dval;
    int          dedge[$];

    CLR    = 1'b1;
    START  = 1'b0;
    BCD_IN = 24'h0;
    #2;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err",  {31'd0, ERR},  32'd0);
    chk("rst_bin",  {12'd0, BIN_OUT}, 32'd0);
    tick();
    CLR = 1'b0;
    tick();

    // Directed values.
    run_conv(24'h999999, "max");
    run_conv(24'h000129, "v129");
    run_conv(24'h000000, "zero");
    run_conv(24'h100000, "v100000");
    run_conv(24'h0012A5, "invalid");
    run_conv(24'h000010, "after_invalid");

    // Randomized values, occasionally with an illegal nibble.
    for (int n = 0; n < 20; n++) begin
      rb = 24'h0;
      for (int i = 0; i < 6; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rb[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      run_conv(rb, $sformatf("rand%0d", n));
    end

    // START re-pulsed at n+2 and n+4 with other data must be ignored.
    model(24'h054321, ev, ee);
    BCD_IN = 24'h054321;
    START  = 1'b1;
    tick();
    dcnt = 0;
    dval = 0;
    for (int k = 1; k <= 14; k++) begin
      START  = (k == 2 || k == 4);
      BCD_IN = (k == 2 || k == 4) ? 24'h777777 : 24'($urandom);
      tick();
      if (DONE === 1'b1) begin
        dcnt++;
        dval = int'(BIN_OUT);
        chk("ignore_done_edge", k, 32'd7);
      end
    end
    START = 1'b0;
    chk("ignore_done_count", dcnt, 32'd1);
    chk("ignore_bin", dval, {12'd0, ev});

    // Back-to-back with START held: DONE every 8 cycles.
    BCD_IN = 24'h000321;
    START  = 1'b1;
    for (int e = 0; e < 26; e++) begin
      tick();
      if (DONE === 1'b1) dedge.push_back(e);
    end
    chk("b2b_count", dedge.size(), 32'd3);
    if (dedge.size() == 3) begin
      chk("b2b_first", dedge[0], 32'd7);
      chk("b2b_gap1", dedge[1] - dedge[0], 32'd8);
      chk("b2b_gap2", dedge[2] - dedge[1], 32'd8);
    end
    chk("b2b_bin", {12'd0, BIN_OUT}, 32'd321);
    START = 1'b0;
    #2;
    CLR = 1'b1;
    #1;
    CLR = 1'b0;
    tick();

    // Leave non-zero outputs, then abort mid-conversion with an async CLR.
    run_conv(24'h0000F1, "pre_abort");
    BCD_IN = 24'h123456;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    tick();
    tick();
    tick();
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_busy", {31'd0, BUSY}, 32'd0);
    chk("clr_done", {31'd0, DONE}, 32'd0);
    chk("clr_err",  {31'd0, ERR},  32'd0);
    chk("clr_bin",  {12'd0, BIN_OUT}, 32'd0);
    #1;
    CLR  = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DONE === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);
    run_conv(24'h000042, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd6_to_bin.md
# bcd6_to_bin

Sequential converter from a packed 6-digit BCD count (the format produced by our BCD event counters) to a 20-bit unsigned binary value. It sits downstream of the BCD counter, so arithmetic logic, comparators and the host interface can consume binary. It uses one multiply-by-10-and-add step per digit, with a START/BUSY/DONE handshake and invalid-digit detection.

## Interface
- DIGITS, 6, number of BCD digits in BCD_IN.
- BIN_W, 20, binary output width; must satisfy 2^BIN_W > 10^DIGITS - 1.
- CLK  in  1  single clock, rising-edge.
- CLR  in  1  reset, asynchronous, active-high.
- START  in  1  conversion request; sampled only while BUSY=0.
- BCD_IN  in  4*DIGITS  packed BCD, digit 0 in [3:0], most significant digit in the top nibble.
- BUSY  out  1  conversion in progress.
- DONE  out  1  one-cycle pulse, BIN_OUT/ERR valid.
- BIN_OUT  out  BIN_W  converted value, held until the next DONE.
- ERR  out  1  last conversion saw a nibble > 9; held until the next DONE.

## Operation
- States: IDLE, CONV, FIN.
- IDLE:
  - BUSY=0.
  - On START=1: capture BCD_IN into the digit shift register, clear the accumulator and the digit counter, and compute the invalid flag (any nibble > 9). Go to CONV.
- CONV:
  - BUSY=1.
  - Each cycle: acc <= (acc<<3) + (acc<<1) + top nibble. Shift the digit register left by 4 and increment the counter.
  - After DIGITS steps, go to FIN.
  - The multiply uses BIN_W+4-bit intermediates, truncated to BIN_W; valid input cannot overflow.
- FIN:
  - DONE=1, BUSY=0.
  - BIN_OUT <= acc, or all-ones (20'hFFFFF) if the invalid flag is set. ERR <= invalid flag.
  - START=1 in this cycle is accepted (capture as in IDLE, go to CONV). Otherwise go to IDLE.
- START while in CONV is ignored. BCD_IN changes after capture have no effect.
- Invalid digits do not shorten latency. The full DIGITS steps run, and the accumulator result is discarded.
- CLR at any time, including mid-conversion:
  - Immediately returns to IDLE.
  - BUSY=0, DONE=0, ERR=0, BIN_OUT=0, accumulator, counter and shift register = 0.
  - No DONE is produced for the aborted conversion.

## Timing
- Reset values: BUSY=0, DONE=0, ERR=0, BIN_OUT=0.
- START sampled high at edge n:
  - BUSY=1 after edges n..n+6.
  - Accumulate steps at edges n+1..n+6.
  - BIN_OUT, ERR and DONE=1 valid after edge n+7; DONE clears at edge n+8.
  - Latency is DIGITS+1 cycles.
- Back-to-back: START held high gives one DONE every DIGITS+2 = 8 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package bcd_pkg:
  - State enum (IDLE, CONV, FIN).
  - Constants DIGITS_DEF=6, BIN_W_DEF=20, BCD_MAX=999999.
  - Digit-valid function (nibble <= 9).
- One sub-module bcd_mul10_add: combinational acc*10 + digit on shifts and adds, instantiated once in the datapath.
- The top level holds the FSM, digit counter, shift register, accumulator and output registers.

## Test plan
- Reset: assert CLR mid-simulation with random state -> BUSY=0, DONE=0, ERR=0, BIN_OUT=0 immediately, without waiting for a clock edge.
- Max value: BCD_IN=24'h999999, START one cycle -> DONE 7 cycles later, BIN_OUT=20'hF423F, ERR=0.
- Typical and zero cases:
  - BCD_IN=24'h000129 -> BIN_OUT=20'h00081.
  - BCD_IN=24'h000000 -> BIN_OUT=0.
  - BCD_IN=24'h100000 -> BIN_OUT=20'h186A0.
- Invalid digit: BCD_IN=24'h0012A5 -> DONE after 7 cycles, ERR=1, BIN_OUT=20'hFFFFF. A following valid 24'h000010 -> ERR=0, BIN_OUT=10.
- Handshake:
  - START pulsed again at edges n+2 and n+4 with different BCD_IN -> ignored, a single DONE with the first value.
  - START held high -> DONE pulses exactly 8 cycles apart.
- Abort: CLR pulsed 3 cycles after START -> no DONE appears. A fresh START with 24'h000042 -> BIN_OUT=42 after 7 cycles.
